// File: rtl/key_repeat_pkg.sv
// Shared types and defaults for the key_repeat_ctrl key-command generator.
package key_repeat_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HOLD,
    REPEAT,
    REL_DB
  } key_state_e;

  localparam int DEF_N_CH          = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_DEBOUNCE      = 250000;
  localparam int DEF_FIRST_DELAY   = 1250000;
  localparam int DEF_REPEAT_PERIOD = 625000;

  // Timer width large enough to hold the largest limit itself (saturated value).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_repeat_ch.sv
// One key channel: input synchroniser, press/release debounce, hold/repeat
// timing and registered command/held outputs.
module key_repeat_ch
  import key_repeat_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DEBOUNCE      = DEF_DEBOUNCE,
  parameter int FIRST_DELAY   = DEF_FIRST_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W         = cnt_width(DEBOUNCE, FIRST_DELAY, REPEAT_PERIOD)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic repeat_en_i,
  output logic cmd_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] FD_LIM = CNT_W'(FIRST_DELAY);
  localparam logic [CNT_W-1:0] RP_LIM = CNT_W'(REPEAT_PERIOD);

  logic [SYNC_STAGES-1:0] sync_q;
  key_state_e             state_q;
  logic                   rep_origin_q;
  logic [CNT_W-1:0]       timer_q;
  logic [CNT_W-1:0]       rel_q;
  logic                   cmd_q;
  logic                   held_q;

  logic             key_s;
  logic             in_repeat;
  logic [CNT_W-1:0] run_lim;
  logic [CNT_W-1:0] run_inc;
  logic             fire;

  // The hold/repeat step is shared by HOLD, REPEAT and the resume edge out of
  // REL_DB, so the limit follows the originating state while debouncing.
  always_comb begin
    key_s     = sync_q[SYNC_STAGES-1];
    in_repeat = (state_q == REPEAT) || ((state_q == REL_DB) && rep_origin_q);
    run_lim   = in_repeat ? RP_LIM : FD_LIM;
    run_inc   = (timer_q >= run_lim) ? run_lim : timer_q + ONE;
    fire      = (run_inc == run_lim) && repeat_en_i;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      state_q      <= IDLE;
      rep_origin_q <= 1'b0;
      timer_q      <= '0;
      rel_q        <= '0;
      cmd_q        <= 1'b0;
      held_q       <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
      cmd_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (key_s) state_q <= PRESS_DB;
        end
        PRESS_DB: begin
          if (!key_s) begin
            state_q <= IDLE;
            timer_q <= '0;
          end else if (timer_q + ONE == DB_LIM) begin
            state_q <= HOLD;
            cmd_q   <= 1'b1;
            held_q  <= 1'b1;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + ONE;
          end
        end
        HOLD, REPEAT: begin
          if (!key_s) begin
            state_q      <= REL_DB;
            rep_origin_q <= (state_q == REPEAT);
            rel_q        <= '0;
          end else if (fire) begin
            state_q <= REPEAT;
            cmd_q   <= 1'b1;
            timer_q <= '0;
          end else begin
            timer_q <= run_inc;
          end
        end
        REL_DB: begin
          if (key_s) begin
            state_q <= (rep_origin_q || fire) ? REPEAT : HOLD;
            if (fire) begin
              cmd_q   <= 1'b1;
              timer_q <= '0;
            end else begin
              timer_q <= run_inc;
            end
          end else if (rel_q + ONE == DB_LIM) begin
            state_q <= IDLE;
            held_q  <= 1'b0;
            timer_q <= '0;
            rel_q   <= '0;
          end else begin
            rel_q <= rel_q + ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_o  = cmd_q;
  assign held_o = held_q;

endmodule

// File: rtl/key_repeat_ctrl.sv
// Multi-channel key-command generator: N_CH independent debounced press and
// auto-repeat channels with one-cycle command pulses.
module key_repeat_ctrl
  import key_repeat_pkg::*;
#(
  parameter int N_CH          = DEF_N_CH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DEBOUNCE      = DEF_DEBOUNCE,
  parameter int FIRST_DELAY   = DEF_FIRST_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter int CNT_W         = cnt_width(DEBOUNCE, FIRST_DELAY, REPEAT_PERIOD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] key,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] cmd,
  output logic [N_CH-1:0] held
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    key_repeat_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE     (DEBOUNCE),
      .FIRST_DELAY  (FIRST_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key_i      (key[g]),
      .repeat_en_i(repeat_en[g]),
      .cmd_o      (cmd[g]),
      .held_o     (held[g])
    );
  end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Self-checking bench for key_repeat_ctrl: behavioural model compared every
// cycle, directed scenarios with literal timing expectations, random stimulus.
`timescale 1ns/1ps
module tb_key_repeat_ctrl;

  localparam int N_CH = 4;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int FD   = 10;
  localparam int RP   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] key;
  logic [N_CH-1:0] repeat_en;
  logic [N_CH-1:0] cmd;
  logic [N_CH-1:0] held;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  key_repeat_ctrl #(
    .N_CH         (N_CH),
    .SYNC_STAGES  (SYNC),
    .DEBOUNCE     (DB),
    .FIRST_DELAY  (FD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .repeat_en(repeat_en),
    .cmd      (cmd),
    .held     (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: observed level is the raw key delayed SYNC edges; a
  // level change counts after DB+1 consecutive observations; active (key-high)
  // held cycles since the last pulse drive the repeat schedule, saturating.
  logic [SYNC-1:0] m_hist [N_CH];
  int              m_run  [N_CH];
  int              m_since[N_CH];
  bit              m_rep  [N_CH];
  logic [N_CH-1:0] m_held;
  logic [N_CH-1:0] m_cmd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        m_hist[c]  <= '0;
        m_run[c]   <= 0;
        m_since[c] <= 0;
        m_rep[c]   <= 1'b0;
      end
      m_held <= '0;
      m_cmd  <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        automatic bit obs   = m_hist[c][SYNC-1];
        automatic bit h     = m_held[c];
        automatic bit pulse = 1'b0;
        automatic int run   = m_run[c];
        automatic int since = m_since[c];
        automatic bit rep   = m_rep[c];
        automatic int lim   = m_rep[c] ? RP : FD;
        if (!h) begin
          run = obs ? run + 1 : 0;
          if (run == DB + 1) begin
            h = 1'b1; pulse = 1'b1; run = 0; since = 0; rep = 1'b0;
          end
        end else if (!obs) begin
          run = run + 1;
          if (run == DB + 1) begin
            h = 1'b0; run = 0;
          end
        end else begin
          run   = 0;
          since = (since + 1 > lim) ? lim : since + 1;
          if (since == lim && repeat_en[c]) begin
            pulse = 1'b1; since = 0; rep = 1'b1;
          end
        end
        m_hist[c]  <= {m_hist[c][SYNC-2:0], key[c]};
        m_run[c]   <= run;
        m_since[c] <= since;
        m_rep[c]   <= rep;
        m_held[c]  <= h;
        m_cmd[c]   <= pulse;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_cmd", 32'(cmd), 32'(m_cmd));
      check("model_held", 32'(held), 32'(m_held));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int pk[16];
  int np;
  int e, k, cnt, other, fall_k, rise_k, misalign;
  bit held_ok;
  int dur[N_CH];

  task automatic clear_pk();
    for (int i = 0; i < 16; i++) pk[i] = -1;
    np = 0;
  endtask

  task automatic note_pulse(input int kk);
    if (np < 16) pk[np] = kk;
    np++;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b0;
    key       = '0;
    repeat_en = '0;
    #1 rst = 1'b1;
    idle_wait(3);
    check("reset_cmd", 32'(cmd), 32'h0);
    check("reset_held", 32'(held), 32'h0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    idle_wait(3);

    // Long hold on key[0] with auto-repeat
    repeat_en = 4'b0001;
    key[0] = 1'b1;
    e = cyc + 1;
    clear_pk(); held_ok = 1'b1; other = 0;
    repeat (60) begin
      @(negedge clk);
      k = cyc - e;
      if (cmd[0]) note_pulse(k);
      if ((k >= 6) != held[0]) held_ok = 1'b0;
      if (cmd[3:1] != 3'b000) other++;
    end
    check("s1_pulse_count", np, 10);
    check("s1_first_pulse", pk[0], 6);
    check("s1_second_pulse", pk[1], 16);
    check("s1_third_pulse", pk[2], 21);
    check("s1_fourth_pulse", pk[3], 26);
    check("s1_held_profile", held_ok, 1);
    check("s1_others_silent", other, 0);
    key[0] = 1'b0;
    idle_wait(20);

    // 3-cycle press glitch on key[1]
    key[1] = 1'b1;
    cnt = 0; other = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 2) key[1] = 1'b0;
      if (cmd[1]) cnt++;
      if (held[1]) other++;
    end
    check("s2_no_cmd", cnt, 0);
    check("s2_no_held", other, 0);
    idle_wait(5);

    // key[2] held without repeat, then repeat enabled while saturated
    repeat_en = 4'b0000;
    key[2] = 1'b1;
    e = cyc + 1;
    clear_pk();
    repeat (30) begin
      @(negedge clk);
      k = cyc - e;
      if (cmd[2]) note_pulse(k);
    end
    check("s3_single_pulse", np, 1);
    check("s3_press_pulse", pk[0], 6);
    repeat_en[2] = 1'b1;
    clear_pk();
    repeat (11) begin
      @(negedge clk);
      k = cyc - e;
      if (cmd[2]) note_pulse(k);
    end
    check("s3_reenable_count", np, 3);
    check("s3_reenable_first", pk[0], 30);
    check("s3_reenable_third", pk[2], 40);
    key[2] = 1'b0;
    repeat_en = 4'b0000;
    idle_wait(20);

    // Release glitch and real release on key[0] in REPEAT
    repeat_en = 4'b0001;
    key[0] = 1'b1;
    e = cyc + 1;
    clear_pk(); held_ok = 1'b1;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      k = cyc - e;
      if (cmd[0]) note_pulse(k);
      if (k >= 6 && !held[0]) held_ok = 1'b0;
      if (k == 18) key[0] = 1'b0;
      if (k == 20) key[0] = 1'b1;
    end
    check("s4_pulse_count", np, 4);
    check("s4_pre_glitch", pk[1], 16);
    check("s4_delayed_pulse", pk[2], 23);
    check("s4_following_pulse", pk[3], 28);
    check("s4_held_through_glitch", held_ok, 1);
    key[0] = 1'b0;
    fall_k = -1; cnt = 0;
    repeat (20) begin
      @(negedge clk);
      k = cyc - e;
      if (!held[0] && fall_k < 0) fall_k = k;
      if (cmd[0]) cnt++;
    end
    check("s4_held_fall", fall_k, 37);
    check("s4_no_pulse_after_drop", cnt, 0);
    idle_wait(10);

    // All keys on the same edge
    repeat_en = 4'b1111;
    key = 4'b1111;
    e = cyc + 1;
    misalign = 0;
    for (int i = 0; i <= 21; i++) begin
      @(negedge clk);
      k = cyc - e;
      if (cmd != 4'b0000 && cmd != 4'b1111) misalign++;
      if (k == 6)  check("s5_press_all", 32'(cmd), 32'hF);
      if (k == 16) check("s5_first_repeat_all", 32'(cmd), 32'hF);
      if (k == 21) check("s5_second_repeat_all", 32'(cmd), 32'hF);
    end
    check("s5_aligned", misalign, 0);
    key = '0;
    repeat_en = '0;
    idle_wait(20);

    // Asynchronous reset on a repeat pulse, then fresh press
    repeat_en = 4'b0001;
    key[0] = 1'b1;
    e = cyc + 1;
    repeat (17) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("s6_rst_cmd", 32'(cmd), 32'h0);
    check("s6_rst_held", 32'(held), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    e = cyc + 1;
    clear_pk(); rise_k = -1;
    repeat (12) begin
      @(negedge clk);
      k = cyc - e;
      if (cmd[0]) note_pulse(k);
      if (held[0] && rise_k < 0) rise_k = k;
    end
    check("s6_fresh_pulse", pk[0], 6);
    check("s6_fresh_held", rise_k, 6);
    key = '0;
    repeat_en = '0;
    idle_wait(20);

    // Randomised levels, glitches and repeat enables against the model
    for (int c = 0; c < N_CH; c++) dur[c] = int'($urandom_range(0, 20));
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int c = 0; c < N_CH; c++) begin
        if (dur[c] == 0) begin
          key[c] = ~key[c];
          dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5))
                                              : int'($urandom_range(6, 60));
        end else begin
          dur[c]--;
        end
      end
      if ($urandom_range(0, 49) == 0) repeat_en = 4'($urandom);
      if (i == 1500) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    key = '0;
    idle_wait(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
